// File: rtl/fwd_pkg.sv
// fwd_pkg: constants and helpers shared by the operand forwarding logic and the hazard unit.
package fwd_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int SEL_RF     = 0;
  function automatic int sel_w(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction
endpackage

// File: rtl/fwd_prio_sel.sv
// fwd_prio_sel: destination-address match against each forwarding source and fixed-priority select.
module fwd_prio_sel
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  localparam int SEL_W  = sel_w(NUM_SRC)
) (
  input  logic [ADDR_W-1:0]             rs_addr,
  input  logic [NUM_SRC-2:0]            fwd_we,
  input  logic [(NUM_SRC-1)*ADDR_W-1:0] fwd_addr,
  output logic [SEL_W-1:0]              sel,
  output logic                          any_hit
);
  logic [NUM_SRC-1:1] hit;
  logic               rs_nz;
  assign rs_nz = rs_addr != ADDR_W'(ZERO_REG);
  for (genvar k = 1; k < NUM_SRC; k++) begin : g_hit
    assign hit[k] = fwd_we[k-1] && fwd_addr[(k-1)*ADDR_W +: ADDR_W] == rs_addr && rs_nz;
  end
  // Scan from the lowest priority upward so the youngest matching source wins.
  always_comb begin
    sel = SEL_W'(SEL_RF);
    for (int k = NUM_SRC - 1; k >= 1; k--)
      if (hit[k]) sel = SEL_W'(k);
  end
  assign any_hit = |hit;
endmodule

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: forwarding operand select registered into the EX input stage,
// with stall/flush control and a saturating forward-hit counter.
module operand_fwd_mux
  import fwd_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = sel_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  input  logic [ADDR_W-1:0]             rs_addr_i,
  input  logic [WIDTH-1:0]              rf_data_i,
  input  logic [NUM_SRC-2:0]            fwd_we_i,
  input  logic [(NUM_SRC-1)*ADDR_W-1:0] fwd_addr_i,
  input  logic [(NUM_SRC-1)*WIDTH-1:0]  fwd_data_i,
  output logic [WIDTH-1:0]              op_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          out_valid_o,
  output logic                          fwd_hit_o,
  output logic [CNT_W-1:0]              fwd_cnt_o
);
  logic [SEL_W-1:0] sel;
  logic             any_hit;
  logic [WIDTH-1:0] data;

  fwd_prio_sel #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) u_sel (
    .rs_addr (rs_addr_i),
    .fwd_we  (fwd_we_i),
    .fwd_addr(fwd_addr_i),
    .sel     (sel),
    .any_hit (any_hit)
  );

  // $zero reads as 0; the select is already 0 then, so only the RF leg needs masking.
  always_comb begin
    data = (rs_addr_i == ADDR_W'(ZERO_REG)) ? '0 : rf_data_i;
    for (int k = 1; k < NUM_SRC; k++)
      if (sel == SEL_W'(k)) data = fwd_data_i[(k-1)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_o        <= '0;
      sel_o       <= SEL_W'(SEL_RF);
      out_valid_o <= 1'b0;
      fwd_hit_o   <= 1'b0;
      fwd_cnt_o   <= '0;
    end else if (flush_i) begin
      op_o        <= '0;
      sel_o       <= SEL_W'(SEL_RF);
      out_valid_o <= 1'b0;
      fwd_hit_o   <= 1'b0;
    end else if (!stall_i) begin
      op_o        <= data;
      sel_o       <= sel;
      out_valid_o <= in_valid_i;
      fwd_hit_o   <= any_hit;
      if (in_valid_i && any_hit && fwd_cnt_o != '1) fwd_cnt_o <= fwd_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_operand_fwd_mux.sv
// tb_operand_fwd_mux: directed checks of select priority, $zero, stall/flush, saturation,
// async reset and a wider/deeper configuration.
module tb_operand_fwd_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_stall, a_flush, a_vld, a_ov, a_hit;
  logic [4:0]  a_rs;
  logic [31:0] a_rf, a_op;
  logic [1:0]  a_we, a_sel;
  logic [9:0]  a_addr;
  logic [63:0] a_data;
  logic [3:0]  a_cnt;

  logic        b_stall, b_flush, b_vld, b_ov, b_hit;
  logic [4:0]  b_rs;
  logic [7:0]  b_rf, b_op;
  logic [3:0]  b_we;
  logic [19:0] b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_sel;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  operand_fwd_mux #(.WIDTH(32), .NUM_SRC(3), .ADDR_W(5), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(a_stall), .flush_i(a_flush), .in_valid_i(a_vld),
    .rs_addr_i(a_rs), .rf_data_i(a_rf), .fwd_we_i(a_we), .fwd_addr_i(a_addr),
    .fwd_data_i(a_data), .op_o(a_op), .sel_o(a_sel), .out_valid_o(a_ov),
    .fwd_hit_o(a_hit), .fwd_cnt_o(a_cnt)
  );

  operand_fwd_mux #(.WIDTH(8), .NUM_SRC(5), .ADDR_W(5), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(b_stall), .flush_i(b_flush), .in_valid_i(b_vld),
    .rs_addr_i(b_rs), .rf_data_i(b_rf), .fwd_we_i(b_we), .fwd_addr_i(b_addr),
    .fwd_data_i(b_data), .op_o(b_op), .sel_o(b_sel), .out_valid_o(b_ov),
    .fwd_hit_o(b_hit), .fwd_cnt_o(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] op, input logic [1:0] sel,
                       input logic ov, input logic hit, input logic [3:0] cnt);
    chk({tag, ".op"}, 64'(a_op), 64'(op));
    chk({tag, ".sel"}, 64'(a_sel), 64'(sel));
    chk({tag, ".valid"}, 64'(a_ov), 64'(ov));
    chk({tag, ".hit"}, 64'(a_hit), 64'(hit));
    chk({tag, ".cnt"}, 64'(a_cnt), 64'(cnt));
  endtask

  initial begin
    a_stall = 0; a_flush = 0; a_vld = 0; a_rs = 0; a_rf = 0; a_we = 0; a_addr = 0; a_data = 0;
    b_stall = 0; b_flush = 0; b_vld = 0; b_rs = 0; b_rf = 0; b_we = 0; b_addr = 0; b_data = 0;
    #12;
    chk_a("reset_a", 32'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    chk("reset_b.sel", 64'(b_sel), 64'd0);
    rst_n = 1'b1;

    // both sources match: src1 (youngest) wins
    a_vld = 1; a_rs = 5; a_we = 2'b11; a_addr = {5'd5, 5'd5};
    a_data = {32'h22, 32'h11}; a_rf = 32'h33;
    tick();
    chk_a("prio", 32'h11, 2'd1, 1'b1, 1'b1, 4'd1);

    a_rs = 7; a_we = 2'b10; a_addr = {5'd3, 5'd7}; a_rf = 32'hDEADBEEF;
    tick();
    chk_a("nomatch", 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 4'd1);

    a_rs = 0; a_we = 2'b01; a_addr = {5'd3, 5'd0}; a_data = {32'h22, 32'hFFFF_FFFF}; a_rf = 32'h1234;
    tick();
    chk_a("zero_reg", 32'h0, 2'd0, 1'b1, 1'b0, 4'd1);

    a_rs = 5; a_we = 2'b01; a_addr = {5'd0, 5'd5}; a_data = {32'h22, 32'h11};
    tick();
    chk_a("capture", 32'h11, 2'd1, 1'b1, 1'b1, 4'd2);

    a_stall = 1; a_data = {32'h22, 32'h99}; a_rs = 5;
    tick(); tick(); tick();
    chk_a("stall", 32'h11, 2'd1, 1'b1, 1'b1, 4'd2);

    a_flush = 1;
    tick();
    chk_a("flush_over_stall", 32'h0, 2'd0, 1'b0, 1'b0, 4'd2);

    a_stall = 0; a_flush = 0; a_vld = 0;
    tick();
    chk_a("invalid_fwd", 32'h99, 2'd1, 1'b0, 1'b1, 4'd2);

    a_vld = 1;
    for (int i = 0; i < 12; i++) tick();
    chk("sat.pre", 64'(a_cnt), 64'd14);
    tick();
    chk("sat.reach", 64'(a_cnt), 64'd15);
    for (int i = 0; i < 7; i++) tick();
    chk("sat.hold", 64'(a_cnt), 64'd15);

    // async reset between edges, then release before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 32'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    #1 rst_n = 1'b1;
    #1;
    chk_a("rst_release", 32'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_a("post_rst", 32'h99, 2'd1, 1'b1, 1'b1, 4'd1);

    // wide/deep config: only src4 matches
    b_vld = 1; b_rs = 9; b_rf = 8'h77;
    b_we = 4'b1000; b_addr = {5'd9, 5'd3, 5'd2, 5'd1};
    b_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    chk("b_src4.sel", 64'(b_sel), 64'd4);
    chk("b_src4.op", 64'(b_op), 64'h44);
    chk("b_src4.hit", 64'(b_hit), 64'd1);
    b_we = 4'b1010; b_addr = {5'd9, 5'd3, 5'd9, 5'd1};
    tick();
    chk("b_src2.sel", 64'(b_sel), 64'd2);
    chk("b_src2.op", 64'(b_op), 64'h22);
    b_we = 4'b1111; b_addr = {5'd9, 5'd9, 5'd9, 5'd9};
    tick();
    chk("b_all.sel", 64'(b_sel), 64'd1);
    chk("b_all.op", 64'(b_op), 64'h11);
    chk("b_all.cnt", 64'(b_cnt), 64'd3);
    b_we = 4'b0000;
    tick();
    chk("b_rf.sel", 64'(b_sel), 64'd0);
    chk("b_rf.op", 64'(b_op), 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
